// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of the output enables of a shared tristate bus.
// Optional hold limit: define TRI_BUS_HOLD_LIMIT_EN.
module tri_bus_arbiter #(
    parameter int N        = 4,
    parameter int TURN_CYC = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N-1:0]                         req,
    output logic [N-1:0]                         oe,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id,
    output logic                                 busy,
    output logic                                 turn
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    oe_q, oe_d;
    logic [IW-1:0]   id_q, id_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            busy_q, busy_d;
    logic            turn_q, turn_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            win_vld;
    logic [IW-1:0]   win_id;
    logic            force_rel;

    // Pick the first requester at or after the pointer, wrapping modulo N
    always_comb begin
        logic [IW:0] sum;
        win_vld = 1'b0;
        win_id  = '0;
        sum     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            if (!win_vld && req[sum[IW-1:0]]) begin
                win_vld = 1'b1;
                win_id  = sum[IW-1:0];
            end
        end
    end

`ifdef TRI_BUS_HOLD_LIMIT_EN
    logic [7:0] hold_q, hold_d;
    logic [7:0] hold_inc;

    // Count completed grant cycles; release a hog once others are waiting
    always_comb begin
        hold_inc  = (hold_q == 8'(MAX_HOLD)) ? hold_q : hold_q + 8'd1;
        force_rel = (state_q == GRANT) && (hold_inc == 8'(MAX_HOLD)) &&
                    (|(req & ~oe_q));
        hold_d    = hold_q;
        if (state_d == GRANT && state_q != GRANT) begin
            hold_d = '0;
        end else if (state_q == GRANT) begin
            hold_d = hold_inc;
        end
    end

    // Hold counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        oe_d    = oe_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        turn_d  = turn_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d      = GRANT;
                    oe_d         = '0;
                    oe_d[win_id] = 1'b1;
                    id_d         = win_id;
                    busy_d       = 1'b1;
                end
            end
            GRANT: begin
                if (!req[id_q] || force_rel) begin
                    state_d = TURN;
                    oe_d    = '0;
                    busy_d  = 1'b0;
                    turn_d  = 1'b1;
                    ptr_d   = (id_q == IW'(N-1)) ? '0 : id_q + 1'b1;
                    cnt_d   = 4'(TURN_CYC);
                end
            end
            TURN: begin
                if (cnt_q == 4'd1) begin
                    turn_d = 1'b0;
                    if (win_vld) begin
                        state_d      = GRANT;
                        oe_d         = '0;
                        oe_d[win_id] = 1'b1;
                        id_d         = win_id;
                        busy_d       = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                oe_d    = '0;
                busy_d  = 1'b0;
                turn_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset kills every enable immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            oe_q    <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            turn_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            oe_q    <= oe_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            turn_q  <= turn_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oe     = oe_q;
    assign gnt_id = id_q;
    assign busy   = busy_q;
    assign turn   = turn_q;

endmodule
